// File: rtl/rrsel_4x32.sv
// rrsel_4x32: round-robin arbiter and capture register for a 4:1 word mux.
// The arbiter drives the mux select S from REQ. It captures the mux output Q
// into a single-entry valid/ready buffer and acknowledges the winner in the
// same cycle. An optional burst rule lets the last winner keep the grant for
// up to BURST consecutive captures.
module rrsel_4x32 #(
  parameter int WIDTH = 32,
  parameter int BURST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       REQ,
  output logic [3:0]       ACK,
  output logic [1:0]       S,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] OUT,
  output logic [1:0]       OUT_SRC,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  logic [1:0] ptr;        // rotation start for the fair scan
  logic [1:0] last;       // most recent winner
  logic [3:0] cnt;        // consecutive captures of last
  logic [3:0] req_rot;    // REQ rotated so that bit 0 is the ptr source
  logic [1:0] scan_pick;
  logic [1:0] pick;
  logic       burst_hit;
  logic       any_req;
  logic       cap;

  // Rotate requests so the priority scan always starts at bit 0.
  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_rot
      assign req_rot[k] = REQ[2'(ptr + 2'(k))];
    end
  endgenerate

  // First set rotated bit wins; the descending loop leaves the lowest index.
  always_comb begin
    scan_pick = ptr;
    for (int i = 3; i >= 0; i--)
      if (req_rot[i]) scan_pick = ptr + 2'(i);
  end

  // Burst continuation is possible only while the holder still requests.
  // With BURST=1, cnt can never be both nonzero and below 1.
  always_comb begin
    any_req   = |REQ;
    burst_hit = REQ[last] && (cnt != 4'd0) && (cnt < 4'(BURST));
    pick      = burst_hit ? last : scan_pick;
    cap       = any_req && (!OUT_VALID || OUT_READY) && !RST;
  end

  // The select follows the pending pick even under backpressure.
  // It parks on last when idle and is forced to 0 during reset.
  always_comb begin
    S   = 2'd0;
    ACK = 4'd0;
    if (!RST) begin
      S   = any_req ? pick : last;
      ACK = cap ? 4'(4'b0001 << pick) : 4'd0;
    end
  end

  // Arbitration state advances only on a capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr  <= 2'd0;
      last <= 2'd0;
      cnt  <= 4'd0;
    end else if (cap) begin
      ptr  <= pick + 2'd1;
      last <= pick;
      cnt  <= burst_hit ? cnt + 4'd1 : 4'd1;
    end
  end

  // Output buffer: a capture replaces the word; a lone consume empties it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT       <= '0;
      OUT_SRC   <= 2'd0;
      OUT_VALID <= 1'b0;
    end else if (cap) begin
      OUT       <= Q;
      OUT_SRC   <= pick;
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rrsel_4x32.sv
// Bench for rrsel_4x32: two instances (BURST=1 and BURST=2) each drive a local
// 4:1 mux model. A reference model checks every cycle, and directed literal
// sequences pin down the expected grant order.
module tb_rrsel_4x32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        started = 1'b0;
  logic [31:0] dat [4];

  logic [3:0]  req  [2];
  logic        rdy  [2];
  logic [3:0]  ack  [2];
  logic [1:0]  s    [2];
  logic [31:0] q    [2];
  logic [31:0] out  [2];
  logic [1:0]  osrc [2];
  logic        ovld [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign q[0] = dat[s[0]];
  assign q[1] = dat[s[1]];

  rrsel_4x32 #(.WIDTH(32), .BURST(1)) u_rr (
    .CLK(clk), .RST(rst), .REQ(req[0]), .ACK(ack[0]), .S(s[0]), .Q(q[0]),
    .OUT(out[0]), .OUT_SRC(osrc[0]), .OUT_VALID(ovld[0]), .OUT_READY(rdy[0]));

  rrsel_4x32 #(.WIDTH(32), .BURST(2)) u_bu (
    .CLK(clk), .RST(rst), .REQ(req[1]), .ACK(ack[1]), .S(s[1]), .Q(q[1]),
    .OUT(out[1]), .OUT_SRC(osrc[1]), .OUT_VALID(ovld[1]), .OUT_READY(rdy[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr  [2];
  int          m_last [2];
  int          m_cnt  [2];
  int          m_src  [2];
  logic        m_vld  [2];
  logic [31:0] m_out  [2];

  function automatic int bw(input int n);
    return (n == 0) ? 1 : 2;
  endfunction

  function automatic bit m_cont(input int n);
    return req[n][m_last[n]] && m_cnt[n] > 0 && m_cnt[n] < bw(n);
  endfunction

  function automatic int m_pick(input int n);
    if (m_cont(n)) return m_last[n];
    for (int j = 0; j < 4; j++)
      if (req[n][(m_ptr[n] + j) % 4]) return (m_ptr[n] + j) % 4;
    return m_last[n];
  endfunction

  function automatic bit m_cap(input int n);
    return (req[n] != 4'd0) && (!m_vld[n] || rdy[n]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_ptr[n] <= 0; m_last[n] <= 0; m_cnt[n] <= 0;
        m_src[n] <= 0; m_vld[n] <= 1'b0; m_out[n] <= 32'd0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (m_cap(n)) begin
          m_out[n]  <= dat[m_pick(n)];
          m_src[n]  <= m_pick(n);
          m_vld[n]  <= 1'b1;
          m_cnt[n]  <= m_cont(n) ? m_cnt[n] + 1 : 1;
          m_last[n] <= m_pick(n);
          m_ptr[n]  <= (m_pick(n) + 1) % 4;
        end else if (rdy[n]) begin
          m_vld[n] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started && !rst) begin
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("mdl_ack%0d", n), 32'(ack[n]),
            m_cap(n) ? 32'(1 << m_pick(n)) : 32'd0);
        chk($sformatf("mdl_s%0d", n), 32'(s[n]),
            (req[n] != 4'd0) ? 32'(m_pick(n)) : 32'(m_last[n]));
        chk($sformatf("mdl_vld%0d", n), 32'(ovld[n]), 32'(m_vld[n]));
        if (m_vld[n]) begin
          chk($sformatf("mdl_src%0d", n), 32'(osrc[n]), 32'(m_src[n]));
          chk($sformatf("mdl_out%0d", n), out[n], m_out[n]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [3:0]  rr_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] rr_out [4] = '{32'h55555555, 32'h0, 32'hAAAAAAAA, 32'hFFFFFFFF};
  logic [3:0]  sp_ack [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
  logic [3:0]  bu_ack [6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001};

  initial begin
    dat[0] = 32'h55555555; dat[1] = 32'h0;
    dat[2] = 32'hAAAAAAAA; dat[3] = 32'hFFFFFFFF;
    req[0] = 4'd0; req[1] = 4'd0; rdy[0] = 1'b1; rdy[1] = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;

    // Round-robin over all four sources, consumer always ready.
    req[0] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ack", 32'(ack[0]), 32'(rr_ack[i]));
      if (i > 0) chk("rr_out", out[0], rr_out[i-1]);
      cyc();
    end

    // Asynchronous reset between edges with all requests active.
    #1 rst = 1'b1;
    #1;
    chk("rst_vld", 32'(ovld[0]), 32'd0);
    chk("rst_out", out[0], 32'd0);
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_s", 32'(s[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Backpressure: one capture, then 3 stalled cycles, then release.
    req[0] = 4'b1111; rdy[0] = 1'b1;
    #1 chk("bp_first_ack", 32'(ack[0]), 32'b0001);
    cyc();
    rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_ack", 32'(ack[0]), 32'd0);
      chk("bp_hold_s", 32'(s[0]), 32'd1);
      chk("bp_hold_out", out[0], 32'h55555555);
      chk("bp_hold_src", 32'(osrc[0]), 32'd0);
      cyc();
    end
    rdy[0] = 1'b1;
    #1 chk("bp_rel_ack", 32'(ack[0]), 32'b0010);
    cyc();
    #1;
    chk("bp_rel_out", out[0], 32'h0);
    chk("bp_rel_src", 32'(osrc[0]), 32'd1);
    chk("bp_rel_vld", 32'(ovld[0]), 32'd1);
    do_reset();

    // Sparse requests with pointer wrap.
    req[0] = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      #1 chk("sp_ack", 32'(ack[0]), 32'(sp_ack[i]));
      cyc();
    end

    // Idle: no ack, select parks on last, buffer drains.
    req[0] = 4'b0000;
    #1;
    chk("idle_ack", 32'(ack[0]), 32'd0);
    chk("idle_s", 32'(s[0]), 32'd3);
    cyc();
    #1;
    chk("idle_vld", 32'(ovld[0]), 32'd0);
    chk("idle_s2", 32'(s[0]), 32'd3);
    chk("idle_out_kept", out[0], 32'hFFFFFFFF);

    // Single source keeps winning every cycle.
    req[0] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("one_ack", 32'(ack[0]), 32'b1000);
      chk("one_s", 32'(s[0]), 32'd3);
      cyc();
    end
    #1 chk("one_src", 32'(osrc[0]), 32'd3);
    req[0] = 4'b0000;
    do_reset();

    // Burst of two per source.
    req[1] = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      #1 chk("bu_ack", 32'(ack[1]), 32'(bu_ack[i]));
      cyc();
    end
    req[1] = 4'b0000;
    do_reset();

    // Burst cut short by the holder dropping its request.
    req[1] = 4'b0101;
    #1 chk("bu_drop_first", 32'(ack[1]), 32'b0001);
    cyc();
    req[1] = 4'b0100;
    #1 chk("bu_drop_next", 32'(ack[1]), 32'b0100);
    cyc();
    req[1] = 4'b0101;
    #1 chk("bu_cnt1_cont", 32'(ack[1]), 32'b0100);
    cyc();

    // Mixed request/ready table for both instances.
    for (int i = 0; i < 24; i++) begin
      req[0] = 4'((i * 7 + 3) % 16);
      rdy[0] = (i % 3) != 0;
      req[1] = 4'((i * 5 + 1) % 16);
      rdy[1] = (i % 4) != 1;
      cyc();
    end
    req[0] = 4'd0; req[1] = 4'd0; rdy[0] = 1'b1; rdy[1] = 1'b1;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rrsel_4x32.md
# rrsel_4x32

Round-robin arbitrated capture stage for the 32-bit four-to-one mux.
- Four requesters present 32-bit words on the mux data inputs A..D.
- This block chooses the winner and drives the mux select `S`.
- It registers the mux output `Q` into a single-entry output buffer with a valid/ready handshake, and returns a one-hot acknowledge to the winning requester.
- It is both the control stage upstream of the mux select and the register stage downstream of the mux data path.

## Interface
Parameters:
- `WIDTH`, 32, data width; must match the mux width.
- `BURST`, 1, maximum consecutive captures from one requester before rotation is forced (1..15).

Ports:
- `CLK`  in  1  clock; rising edge active.
- `RST`  in  1  reset; asynchronous, active-high.
- `REQ`  in  4  request per source; bit i means the word on mux input i is valid.
- `ACK`  out  4  one-hot, combinational; bit i high means source i's word is captured at this edge.
- `S`  out  2  mux select, combinational; drives the mux `S`.
- `Q`  in  WIDTH  mux output, selected by `S`.
- `OUT`  out  WIDTH  captured word, registered.
- `OUT_SRC`  out  2  index of the source of `OUT`, registered.
- `OUT_VALID`  out  1  `OUT` holds an unconsumed word.
- `OUT_READY`  in  1  consumer accepts `OUT` at this edge.

## Operation
Internal registers:
- `PTR[1:0]`: rotation start.
- `LAST[1:0]`: last granted source.
- `CNT[3:0]`: consecutive captures of `LAST`.

Capture enable: `CAP = |REQ && (!OUT_VALID || OUT_READY)`.

Pick (combinational):
- If `REQ[LAST]`, `CNT != 0` and `CNT < BURST`, the pick is `LAST` (burst continuation).
- Otherwise the pick is the first set bit of `REQ`, scanning `PTR`, `PTR+1`, `PTR+2`, `PTR+3` (mod 4).

Combinational outputs:
- `S` = pick when `|REQ`, else `LAST`.
- `ACK` = onehot(pick) when `CAP`, else 0.
- While `RST` is high, `ACK` = 0 and `S` = 0.

On a rising edge with `CAP`:
- `OUT <= Q`, `OUT_SRC <= pick`, `OUT_VALID <= 1`, `LAST <= pick`, `PTR <= pick+1` (mod 4, wraps 3 to 0).
- `CNT <= CNT+1` if the pick was a burst continuation, else 1.

On a rising edge without `CAP`:
- If `OUT_READY` is high, `OUT_VALID <= 0`.
- `OUT`, `OUT_SRC`, `LAST`, `PTR` and `CNT` hold.

Boundary behaviour:
- A requester holds `REQ` and its data stable until it sees `ACK` high at an edge. It may drop `REQ` at any time before that; no capture occurs for it.
- `REQ` = 0: no capture, no `ACK`, `S` = `LAST`.
- With `BURST` = 1 the burst rule never fires, giving pure round-robin.
- A burst ends early when the holder drops `REQ`. The scan then starts at `PTR` (= `LAST+1`).
- `OUT` is don't-care when `OUT_VALID` = 0, but it is not cleared except by reset.

## Timing
- Reset values: `OUT` = 0, `OUT_SRC` = 0, `OUT_VALID` = 0, `PTR` = 0, `LAST` = 0, `CNT` = 0. Source 0 has first priority after reset.
- `REQ` to `ACK`/`S`: same cycle (combinational).
- `ACK` edge to `OUT_VALID`: 1 cycle.
- Throughput: one word per cycle when `OUT_READY` is held high.
- Same-edge consume and capture: `OUT` is replaced with no bubble and `OUT_VALID` stays 1.
- `OUT_VALID` && !`OUT_READY`: `CAP` = 0, `OUT` is stable, `S` still reflects the pending pick.
- `RST` asserted mid-stream clears all state immediately:
  - A buffered word is lost.
  - No `ACK` is given while `RST` is high.
  - After the first edge following deassertion, arbitration restarts from source 0.

## Test plan
- Reset: assert `RST` asynchronously between edges with `REQ` = 1111. Required immediately: `OUT_VALID` = 0, `OUT` = 0, `ACK` = 0000, `S` = 0, before any clock edge.
- Round-robin (`BURST` = 1), with a `fourmux_32` instance wired as the real data path:
  - Stimulus: A = 0x55555555, B = 0, C = 0xAAAAAAAA, D = 0xFFFFFFFF, `REQ` = 1111, `OUT_READY` = 1.
  - Required: `ACK` sequence 0001, 0010, 0100, 1000, 0001.
  - Required: `OUT` = 0x55555555, 0, 0xAAAAAAAA, 0xFFFFFFFF on the following edges.
- Backpressure:
  - Stimulus: after the first capture, hold `OUT_READY` = 0 for 3 cycles.
  - Required during the hold: `ACK` = 0000, `OUT` and `OUT_SRC` stable, `S` = 1.
  - Required on the release cycle: `ACK` = 0010 and `OUT` = B on the next edge, with no bubble.
- Sparse requests and wrap-around: `REQ` = 1001, `OUT_READY` = 1. Required grants: 0, 3, 0, 3 (`PTR` wraps from 3 to 0).
- Burst (instance with `BURST` = 2), `REQ` = 0101:
  - Required grants: 0, 0, 2, 2, 0, 0.
  - Variant: drop `REQ[0]` after the first grant. Required: the next grant is 2 and `CNT` = 1.
- Idle and single source:
  - `REQ` = 0000: no `ACK`, `S` holds `LAST`, `OUT_VALID` falls after one `OUT_READY` edge.
  - `REQ` = 1000: `ACK` = 1000 every cycle, `S` = 3, `OUT_SRC` = 3.
